// File: rtl/pic_ctrl_param.sv
// Parametrised programmable interrupt controller: masked edge/level request capture,
// fixed or rotating priority with fully nested in-service tracking, INT/INTA vector handshake.
module pic_ctrl_param #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3,
  parameter int BUS_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [1:0]         addr,
  input  logic [BUS_W-1:0]   wdata,
  output logic [BUS_W-1:0]   rdata,
  output logic               int_out,
  input  logic               inta,
  output logic [7:0]         vector,
  output logic               vector_valid
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_prev_q, edge_det;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, elcr_q, eligible;
  logic [7:0]         vbase_q, vector_q, vector_d;
  logic               rotate_en_q, rotate_en_d;
  logic [ID_W-1:0]    prio_ptr_q, prio_ptr_d, eff_ptr, idx;
  logic [ID_W-1:0]    cand_id, isr_top_id, eoi_id, spec_id;
  logic               cand_found, cand_valid, isr_seen;
  logic               cmd_wr, eoi_hit, ack_fire, ack_take;
  logic [BUS_W-1:0]   rdata_q;
  logic               unused_bits;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_IRQ) s = s - NUM_IRQ;
    return ID_W'(s);
  endfunction

  // Walk lines from highest to lowest priority; a candidate is only valid if no
  // in-service line at the same or higher priority was passed on the way.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    eff_ptr    = rotate_en_q ? prio_ptr_q : '0;
    eligible   = irr_q & ~imr_q;
    idx        = '0;
    cand_found = 1'b0;
    cand_valid = 1'b0;
    cand_id    = '0;
    isr_seen   = 1'b0;
    isr_top_id = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = wrap_idx(eff_ptr, k);
      if (!cand_found && eligible[idx]) begin
        cand_found = 1'b1;
        cand_id    = idx;
        cand_valid = !isr_seen && !isr_q[idx];
      end
      if (!isr_seen && isr_q[idx]) begin
        isr_seen   = 1'b1;
        isr_top_id = idx;
      end
    end
  end

  assign spec_id  = wdata[ID_W-1:0];
  assign cmd_wr   = wr_en && (addr == 2'd3);
  assign ack_fire = inta && (state_q != ACK);
  assign ack_take = ack_fire && (state_q == PEND) && cand_valid;
  assign edge_det = irq_q & ~irq_prev_q;

  always_comb begin
    eoi_hit     = 1'b0;
    eoi_id      = '0;
    rotate_en_d = rotate_en_q;
    if (cmd_wr) begin
      case (wdata[7:6])
        2'b01: begin
          eoi_hit = isr_seen;
          eoi_id  = isr_top_id;
        end
        2'b10: begin
          if (int'(spec_id) < NUM_IRQ && isr_q[spec_id]) begin
            eoi_hit = 1'b1;
            eoi_id  = spec_id;
          end
        end
        2'b11:   rotate_en_d = wdata[5];
        default: ;
      endcase
    end

    prio_ptr_d = prio_ptr_q;
    if (eoi_hit && rotate_en_q) prio_ptr_d = wrap_idx(eoi_id, 1);

    // EOI clears against the old ISR; an acknowledge in the same cycle sets on top.
    isr_d = isr_q;
    if (eoi_hit)  isr_d[eoi_id]  = 1'b0;
    if (ack_take) isr_d[cand_id] = 1'b1;

    for (int i = 0; i < NUM_IRQ; i++) begin
      irr_d[i] = elcr_q[i] ? (edge_det[i] | (irr_q[i] & ~(ack_take && cand_id == ID_W'(i))))
                           : irq_q[i];
    end

    vector_d = vector_q;
    if (ack_fire) begin
      vector_d = ack_take ? {vbase_q[7:ID_W], cand_id} : {vbase_q[7:ID_W], {ID_W{1'b1}}};
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (inta) state_d = ACK; else if (cand_valid) state_d = PEND;
      PEND:    if (inta) state_d = ACK; else if (!cand_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      irq_prev_q  <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '1;
      elcr_q      <= '1;
      vbase_q     <= '0;
      rotate_en_q <= 1'b0;
      prio_ptr_q  <= '0;
      vector_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq;
      irq_prev_q  <= irq_q;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      rotate_en_q <= rotate_en_d;
      prio_ptr_q  <= prio_ptr_d;
      vector_q    <= vector_d;
      if (wr_en) begin
        case (addr)
          2'd0:    imr_q   <= wdata[NUM_IRQ-1:0];
          2'd1:    elcr_q  <= wdata[NUM_IRQ-1:0];
          2'd2:    vbase_q <= wdata[7:0];
          default: ;
        endcase
      end
      if (rd_en) begin
        case (addr)
          2'd0:    rdata_q <= BUS_W'(imr_q);
          2'd1:    rdata_q <= BUS_W'(elcr_q);
          2'd2:    rdata_q <= BUS_W'(irr_q);
          default: rdata_q <= BUS_W'(isr_q);
        endcase
      end
    end
  end

  assign int_out      = (state_q == PEND);
  assign vector_valid = (state_q == ACK);
  assign vector       = vector_q;
  assign rdata        = rdata_q;
  assign unused_bits  = ^{wdata, vbase_q};

endmodule

// File: tb/tb_pic_ctrl_param.sv
// Self-checking bench for pic_ctrl_param: register table, directed handshake
// sequences, a 16-line instance, and randomized traffic against a reference model.
module tb_pic_ctrl_param;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, inta = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        int_out, vector_valid;
  logic [7:0]  vector;

  logic [15:0] irq16 = '0;
  logic        wr16 = 1'b0, rd16 = 1'b0, inta16 = 1'b0;
  logic [1:0]  addr16 = '0;
  logic [15:0] wdata16 = '0;
  logic [15:0] rdata16;
  logic        int16, vv16;
  logic [7:0]  vec16;

  int n_checks = 0;
  int n_fail   = 0;
  logic rnd_on = 1'b0;

  always #5 clk = ~clk;

  pic_ctrl_param #(.NUM_IRQ(8), .ID_W(3), .BUS_W(16)) u_dut (
    .clk(clk), .rst(rst), .irq(irq), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_out(int_out), .inta(inta),
    .vector(vector), .vector_valid(vector_valid)
  );

  pic_ctrl_param #(.NUM_IRQ(16), .ID_W(4), .BUS_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .irq(irq16), .wr_en(wr16), .rd_en(rd16), .addr(addr16),
    .wdata(wdata16), .rdata(rdata16), .int_out(int16), .inta(inta16),
    .vector(vec16), .vector_valid(vv16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
    v = rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq = irq | m;
    step();
    irq = irq & ~m;
  endtask

  task automatic do_inta(output logic [7:0] v, output logic vv);
    inta = 1'b1;
    step();
    inta = 1'b0;
    v  = vector;
    vv = vector_valid;
  endtask

  // Reference model: priority by rank arithmetic, state tracked as plain values.
  logic [7:0]  m_imr, m_elcr, m_irr, m_isr, m_vbase, m_irq1, m_irq2, m_vector;
  logic [15:0] m_rdata;
  logic        m_rot;
  int          m_ptr, m_phase;   // phase: 0 idle, 1 int pending, 2 vector cycle

  always @(posedge clk) begin : model
    int ep, best, best_rank, top, top_rank, eoi_id, r, nphase;
    logic cvalid, ack_ok, nrot;
    logic [7:0] nisr, nirr, edge_v;
    if (rst) begin
      m_imr <= 8'hFF; m_elcr <= 8'hFF; m_irr <= '0; m_isr <= '0; m_vbase <= '0;
      m_rot <= 1'b0; m_ptr <= 0; m_irq1 <= '0; m_irq2 <= '0; m_phase <= 0;
      m_vector <= '0; m_rdata <= '0;
    end else begin
      ep = m_rot ? m_ptr : 0;
      best = -1; best_rank = N; top = -1; top_rank = N;
      for (int i = 0; i < N; i++) begin
        r = (i - ep + N) % N;
        if (m_irr[i] && !m_imr[i] && r < best_rank) begin best = i; best_rank = r; end
        if (m_isr[i] && r < top_rank) begin top = i; top_rank = r; end
      end
      cvalid = (best >= 0) && (best_rank < top_rank);

      eoi_id = -1;
      nrot   = m_rot;
      if (wr_en && addr == 2'd3) begin
        case (wdata[7:6])
          2'b01:   if (top >= 0) eoi_id = top;
          2'b10:   if (m_isr[wdata[2:0]]) eoi_id = int'(wdata[2:0]);
          2'b11:   nrot = wdata[5];
          default: ;
        endcase
      end
      ack_ok = inta && (m_phase == 1) && cvalid;

      nisr = m_isr;
      if (eoi_id >= 0) nisr[eoi_id] = 1'b0;
      if (ack_ok) nisr[best] = 1'b1;

      edge_v = m_irq1 & ~m_irq2;
      for (int i = 0; i < N; i++) begin
        if (m_elcr[i]) nirr[i] = edge_v[i] | (m_irr[i] && !(ack_ok && best == i));
        else           nirr[i] = m_irq1[i];
      end

      if (m_phase == 2)  nphase = 0;
      else if (inta)     nphase = 2;
      else               nphase = cvalid ? 1 : 0;

      if (inta && m_phase != 2)
        m_vector <= ack_ok ? {m_vbase[7:3], 3'(best)} : {m_vbase[7:3], 3'b111};
      if (eoi_id >= 0 && m_rot) m_ptr <= (eoi_id + 1) % N;
      if (wr_en) begin
        case (addr)
          2'd0:    m_imr   <= wdata[7:0];
          2'd1:    m_elcr  <= wdata[7:0];
          2'd2:    m_vbase <= wdata[7:0];
          default: ;
        endcase
      end
      if (rd_en) begin
        case (addr)
          2'd0:    m_rdata <= {8'h00, m_imr};
          2'd1:    m_rdata <= {8'h00, m_elcr};
          2'd2:    m_rdata <= {8'h00, m_irr};
          default: m_rdata <= {8'h00, m_isr};
        endcase
      end
      m_isr <= nisr; m_irr <= nirr; m_irq2 <= m_irq1; m_irq1 <= irq;
      m_phase <= nphase; m_rot <= nrot;
    end
  end

  always @(negedge clk) begin
    if (rnd_on) begin
      check("rnd_int_out", int_out, m_phase == 1);
      check("rnd_vector_valid", vector_valid, m_phase == 2);
      check("rnd_vector", vector, m_vector);
      check("rnd_rdata", rdata, m_rdata);
    end
  end

  typedef struct {
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  ra;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [15:0] v;
    logic [7:0]  vec;
    logic        vv;

    tbl = '{
      '{2'd0, 16'h005A, 2'd0, 16'h005A},
      '{2'd1, 16'h00C3, 2'd1, 16'h00C3},
      '{2'd0, 16'hFF12, 2'd0, 16'h0012},
      '{2'd1, 16'hAB00, 2'd1, 16'h0000},
      '{2'd3, 16'h0000, 2'd3, 16'h0000},
      '{2'd2, 16'h0040, 2'd2, 16'h0000}
    };

    step(2);
    rst = 1'b0;
    check("rst_int_out", int_out, 1'b0);
    check("rst_vector_valid", vector_valid, 1'b0);
    check("rst_vector", vector, 8'h00);
    check("rst_rdata", rdata, 16'h0000);
    rd(2'd0, v); check("rst_imr", v, 16'h00FF);
    rd(2'd1, v); check("rst_elcr", v, 16'h00FF);
    rd(2'd2, v); check("rst_irr", v, 16'h0000);
    rd(2'd3, v); check("rst_isr", v, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, v);
      check($sformatf("tbl_%0d", i), v, tbl[i].exp);
    end

    // Basic edge request and acknowledge, with the three-cycle latency boundary.
    wr(2'd0, 16'h0000); wr(2'd1, 16'h00FF); wr(2'd2, 16'h0040);
    pulse(8'h08);
    check("lat_c1", int_out, 1'b0);
    step(); check("lat_c2", int_out, 1'b0);
    step(); check("lat_c3", int_out, 1'b1);
    do_inta(vec, vv);
    check("ack3_vector", vec, 8'h43);
    check("ack3_valid", vv, 1'b1);
    check("ack3_int_low", int_out, 1'b0);
    step(); check("ack3_valid_once", vector_valid, 1'b0);
    rd(2'd3, v); check("ack3_isr", v, 16'h0008);
    rd(2'd2, v); check("ack3_irr", v, 16'h0000);

    // Nesting: lower priority blocked, higher priority nests.
    pulse(8'h20); step(4);
    check("nest_blocked", int_out, 1'b0);
    rd(2'd2, v); check("nest_irr5", v, 16'h0020);
    pulse(8'h02); step(2);
    check("nest_int1", int_out, 1'b1);
    do_inta(vec, vv); check("nest_vec1", vec, 8'h41);
    rd(2'd3, v); check("nest_isr", v, 16'h000A);
    wr(2'd3, 16'h0040);
    rd(2'd3, v); check("nest_nseoi", v, 16'h0008);
    wr(2'd3, 16'h0083);
    step(); check("nest_int5", int_out, 1'b1);
    do_inta(vec, vv); check("nest_vec5", vec, 8'h45);
    wr(2'd3, 16'h0040);
    rd(2'd3, v); check("nest_isr_clr", v, 16'h0000);

    // Level line withdrawn while pending, then a spurious acknowledge.
    wr(2'd1, 16'h00FB);
    irq = 8'h04; step(3);
    check("lvl_int", int_out, 1'b1);
    irq = 8'h00; step(2);
    check("lvl_hold", int_out, 1'b1);
    step(); check("lvl_drop", int_out, 1'b0);
    do_inta(vec, vv);
    check("lvl_spur_vec", vec, 8'h47);
    check("lvl_spur_valid", vv, 1'b1);
    rd(2'd3, v); check("lvl_isr", v, 16'h0000);
    wr(2'd1, 16'h00FF);

    // Rotation: after EOI of line 0 it becomes lowest priority.
    wr(2'd3, 16'h00E0);
    pulse(8'h01); step(2);
    do_inta(vec, vv); check("rot_vec0", vec, 8'h40);
    wr(2'd3, 16'h0040);
    pulse(8'h11); step(2);
    check("rot_int", int_out, 1'b1);
    do_inta(vec, vv); check("rot_vec4", vec, 8'h44);
    wr(2'd3, 16'h0040);
    step(); check("rot_int_next", int_out, 1'b1);
    do_inta(vec, vv); check("rot_vec0b", vec, 8'h40);
    wr(2'd3, 16'h0040);
    wr(2'd3, 16'h00C0);
    rd(2'd3, v); check("rot_isr", v, 16'h0000);

    // Mask: all masked, then unmask line 7 only.
    wr(2'd0, 16'h00FF);
    pulse(8'hFF); step(3);
    check("mask_int", int_out, 1'b0);
    rd(2'd2, v); check("mask_irr", v, 16'h00FF);
    wr(2'd0, 16'h007F);
    step(); check("mask_int7", int_out, 1'b1);
    do_inta(vec, vv); check("mask_vec7", vec, 8'h47);
    rd(2'd3, v); check("mask_isr", v, 16'h0080);

    // Reset while an interrupt is pending.
    wr(2'd0, 16'h0000);
    step(); check("mid_int", int_out, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_int", int_out, 1'b0);
    rd(2'd3, v); check("mid_rst_isr", v, 16'h0000);
    rd(2'd0, v); check("mid_rst_imr", v, 16'h00FF);
    rd(2'd2, v); check("mid_rst_irr", v, 16'h0000);

    // 16-line instance: line 12 with VBASE 0xA0.
    wr16 = 1'b1; addr16 = 2'd0; wdata16 = 16'h0000; step();
    addr16 = 2'd2; wdata16 = 16'h00A0; step();
    wr16 = 1'b0;
    irq16 = 16'h1000; step(); irq16 = '0; step(2);
    check("n16_int", int16, 1'b1);
    inta16 = 1'b1; step(); inta16 = 1'b0;
    check("n16_vec", vec16, 8'hAC);
    check("n16_valid", vv16, 1'b1);

    // Randomized traffic compared against the reference model every cycle.
    rst = 1'b1; step(2); rst = 1'b0;
    rnd_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int sel, start;
      wr_en = ($urandom % 6) == 0;
      rd_en = ($urandom % 4) == 0;
      addr  = 2'($urandom % 4);
      wdata = 16'($urandom);
      if (wr_en && addr == 2'd0) wdata = {8'h00, 8'($urandom) & 8'($urandom)};
      if (wr_en && addr == 2'd3) begin
        sel = $urandom % 4;
        case (sel)
          0: wdata = 16'h0000;
          1: wdata = 16'h0040;
          2: begin
            wdata = 16'h0000;
            start = $urandom % N;
            for (int k = N - 1; k >= 0; k--)
              if (m_isr[(start + k) % N]) wdata = 16'h0080 | 16'((start + k) % N);
          end
          default: wdata = {8'h00, 2'b11, 1'($urandom), 5'b0};
        endcase
      end
      inta = (($urandom % 5) == 0) && (m_phase != 2);
      irq  = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      step();
    end
    wr_en = 1'b0; rd_en = 1'b0; inta = 1'b0;
    step();
    rnd_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
